// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the extended UART receiver:
//   - receiver FSM state codes
//   - data-bits configuration encoding and a helper that maps it to the
//     index of the last data bit
//   - layout of a FIFO word and of the rx_err flag pair
// -----------------------------------------------------------------------------
package uart_pkg;

    // Receiver FSM state codes.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_BRK_WAIT = 3'd5;

    // cfg_data_bits encoding.
    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    // FIFO word: {parity_err, frame_err, data[7:0]}.
    localparam int FIFO_WIDTH   = 10;
    localparam int WORD_PAR_BIT = 9;
    localparam int WORD_FRM_BIT = 8;

    // Positions of the flags inside rx_err.
    localparam int ERR_PARITY_BIT = 1;
    localparam int ERR_FRAME_BIT  = 0;

    // Index of the last data bit for a given encoding (5 bits -> 4 ... 8 -> 7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] enc);
        return 3'd4 + {1'b0, enc};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous first-word-fall-through FIFO for received characters.
// The head entry is presented on rd_data whenever valid is high; rd_data is
// forced to zero while empty so the outputs are clean out of reset.
// A push into a full FIFO is dropped (drop pulses) unless a pop happens in the
// same cycle, in which case both succeed.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wr_data     write strobe and word
//   pop               read strobe (ignored while empty)
//   rd_data           head word (0 when empty)
//   valid             FIFO not empty
//   level             number of entries held, 0..DEPTH
//   drop              a push was discarded because the FIFO was full
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (level != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((level != LVL_FULL) || do_pop);
    assign drop    = push && !do_push;
    assign rd_data = valid ? mem[rd_ptr] : '0;

    // NOTE: storage has no reset; the pointers and level define which entries
    // are meaningful, so resetting the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ext.sv
// -----------------------------------------------------------------------------
// uart_rx_ext
// Configurable UART receiver (5..8 data bits, optional odd/even parity,
// one or two stop bits) with break detection, a first-word-fall-through
// receive FIFO and a sticky overrun flag.
//
// Optional feature: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3
// majority of the samples at mid-1, mid and mid+1; otherwise one sample at mid.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx                    asynchronous serial input, idle high
//   baud_div              clocks per bit (values below 4 are treated as 4)
//   cfg_data_bits         00=5, 01=6, 10=7, 11=8 data bits
//   cfg_parity_en/odd     parity enable, odd parity select
//   cfg_stop2             two stop bits
//   rx_data, rx_err       FIFO head: data (upper bits 0), {parity_err, frame_err}
//   rx_valid, rx_ready    FIFO not empty / pop request
//   fifo_level            FIFO occupancy
//   overrun, ovr_clr      sticky "character dropped" flag and its clear
//   break_det             one-cycle pulse when a break frame is received
// -----------------------------------------------------------------------------
module uart_rx_ext #(
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD_DIV_WIDTH = 16,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic [BAUD_DIV_WIDTH-1:0]     baud_div,
    input  logic [1:0]                    cfg_data_bits,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    output logic [7:0]                    rx_data,
    output logic [1:0]                    rx_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          break_det
);

    import uart_pkg::*;

    localparam int            BW      = BAUD_DIV_WIDTH;
    localparam logic [BW-1:0] MIN_DIV = BW'(4);
    localparam logic [BW-1:0] CNT_ONE = BW'(1);

    // Synchroniser and frame state.
    logic                  rx_s1;
    logic                  rx_sync;
    logic [2:0]            state;
    logic [BW-1:0]         cnt;
    logic [BW-1:0]         div_q;
    logic [1:0]            bits_q;
    logic                  par_en_q;
    logic                  par_odd_q;
    logic                  stop2_q;
    logic [2:0]            bit_idx;
    logic                  stop_idx;
    logic [7:0]            shreg;
    logic                  par_err_q;
    logic                  par_bit_q;
    logic                  frm_err_q;

    // Combinational helpers.
    logic [BW-1:0]         div_eff;
    logic [BW-1:0]         mid;
    logic                  sample_now;
    logic                  sample_bit;
    logic                  last_data;
    logic                  last_stop;
    logic                  frm_err_fin;
    logic                  is_break;
    logic                  push;
    logic [FIFO_WIDTH-1:0] push_word;
    logic [FIFO_WIDTH-1:0] head_word;
    logic                  fifo_drop;

    assign div_eff = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;

    // START samples half a bit in. After any sample the counter restarts, so
    // the next bit centre is D-1 counts later; in majority mode the decision
    // is taken one clock after the centre, so the centre moves to D-2.
    // NOTE: every output of this block gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        if (state == ST_START) begin
            mid = (div_q >> 1) - CNT_ONE;
        end else begin
`ifdef UART_RX_MAJORITY_EN
            mid = div_q - BW'(2);
`else
            mid = div_q - CNT_ONE;
`endif
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [BW-1:0] mid_m1;
    logic [BW-1:0] mid_p1;
    logic          maj_s0;
    logic          maj_s1;

    assign mid_m1     = mid - CNT_ONE;
    assign mid_p1     = mid + CNT_ONE;
    assign sample_now = (cnt == mid_p1);
    assign sample_bit = (maj_s0 & maj_s1) | (maj_s0 & rx_sync) | (maj_s1 & rx_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_s0 <= 1'b1;
            maj_s1 <= 1'b1;
        end else begin
            if (cnt == mid_m1) begin
                maj_s0 <= rx_sync;
            end
            if (cnt == mid) begin
                maj_s1 <= rx_sync;
            end
        end
    end
`else
    assign sample_now = (cnt == mid);
    assign sample_bit = rx_sync;
`endif

    assign last_data   = (bit_idx == last_bit_idx(bits_q));
    assign last_stop   = !stop2_q || stop_idx;
    assign frm_err_fin = frm_err_q | ~sample_bit;
    // A break is a framing error on an all-zero character (parity bit included).
    assign is_break    = frm_err_fin && (shreg == 8'h00) && (!par_en_q || !par_bit_q);
    assign push        = (state == ST_STOP) && sample_now && last_stop;

    always_comb begin
        push_word               = '0;
        push_word[7:0]          = shreg;
        push_word[WORD_PAR_BIT] = par_err_q;
        push_word[WORD_FRM_BIT] = frm_err_fin;
    end

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_sync <= rx_s1;
        end
    end

    // Bit-period counter: restarts at every sample decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == ST_IDLE || state == ST_BRK_WAIT || sample_now) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_q     <= MIN_DIV;
            bits_q    <= DBITS_8;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            par_err_q <= 1'b0;
            par_bit_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state     <= ST_START;
                        div_q     <= div_eff;
                        bits_q    <= cfg_data_bits;
                        par_en_q  <= cfg_parity_en;
                        par_odd_q <= cfg_parity_odd;
                        stop2_q   <= cfg_stop2;
                    end
                end
                ST_START: begin
                    if (sample_now) begin
                        if (!sample_bit) begin
                            state     <= ST_DATA;
                            bit_idx   <= '0;
                            stop_idx  <= 1'b0;
                            shreg     <= '0;
                            par_err_q <= 1'b0;
                            par_bit_q <= 1'b0;
                            frm_err_q <= 1'b0;
                        end else begin
                            state <= ST_IDLE;  // glitch: line went high again
                        end
                    end
                end
                ST_DATA: begin
                    if (sample_now) begin
                        shreg[bit_idx] <= sample_bit;
                        bit_idx        <= bit_idx + 3'd1;
                        if (last_data) begin
                            state <= par_en_q ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample_now) begin
                        par_bit_q <= sample_bit;
                        par_err_q <= sample_bit != (^shreg ^ par_odd_q);
                        state     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample_now) begin
                        frm_err_q <= frm_err_fin;
                        stop_idx  <= 1'b1;
                        if (last_stop) begin
                            state <= is_break ? ST_BRK_WAIT : ST_IDLE;
                        end
                    end
                end
                ST_BRK_WAIT: begin
                    if (rx_sync) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            break_det <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            break_det <= push && is_break;
            // A new drop wins over a simultaneous clear.
            if (fifo_drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_word),
        .pop     (rx_ready),
        .rd_data (head_word),
        .valid   (rx_valid),
        .level   (fifo_level),
        .drop    (fifo_drop)
    );

    assign rx_data                = head_word[7:0];
    assign rx_err[ERR_PARITY_BIT] = head_word[WORD_PAR_BIT];
    assign rx_err[ERR_FRAME_BIT]  = head_word[WORD_FRM_BIT];

endmodule

// File: tb/tb_uart_rx_ext.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ext
// Directed self-checking bench for uart_rx_ext with baud_div = 16.
// Serial bits are driven on the line for 16 clocks each, changing 1 time unit
// after a rising edge; outputs are sampled 1 time unit after a rising edge.
// With the line falling just after edge P0, the last stop-bit decision of an
// 8N1 frame lands on edge P155 (2 sync + 1 detect + 8 half-bit + 9*16),
// one edge later when UART_RX_MAJORITY_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_ext;

    localparam int D = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'd16;
    logic [1:0]  cfg_data_bits = 2'b11;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        cfg_stop2 = 1'b0;
    logic [7:0]  rx_data;
    logic [1:0]  rx_err;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic        overrun;
    logic        ovr_clr = 1'b0;
    logic        break_det;

    int n_cmp = 0;
    int n_err = 0;
    int brk_pulses = 0;
    int brk_before;

    uart_rx_ext #(
        .CLK_FREQ       (50000000),
        .BAUD_DIV_WIDTH (16),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx             (rx),
        .baud_div       (baud_div),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_data        (rx_data),
        .rx_err         (rx_err),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .fifo_level     (fifo_level),
        .overrun        (overrun),
        .ovr_clr        (ovr_clr),
        .break_det      (break_det)
    );

    always #5 clk = ~clk;

    // Counts clock cycles during which break_det is high.
    always @(negedge clk) begin
        if (break_det === 1'b1) brk_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (D) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                              input bit par_bit, input bit stop0, input bit has_stop2,
                              input bit stop1);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par_bit);
        drive_bit(stop0);
        if (has_stop2) drive_bit(stop1);
        rx = 1'b1;
    endtask

    // 8N1 frame; the push edge is known exactly, so ovr_clr / rx_ready can be
    // placed on it and rx_valid can be checked on either side of it.
    task automatic send_8n1(input logic [7:0] d, input bit chk_lat,
                            input bit clr_at_push, input bit pop_at_push);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        rx = 1'b1;
        repeat (10 + MAJ) @(posedge clk);
        #1;
        if (chk_lat) check("valid_before_push", rx_valid, 0);
        ovr_clr  = clr_at_push;
        rx_ready = pop_at_push;
        @(posedge clk);
        #1;
        ovr_clr  = 1'b0;
        rx_ready = 1'b0;
        if (chk_lat) check("valid_after_push", rx_valid, 1);
        repeat (5 - MAJ) @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic [1:0] e);
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_data"}, rx_data, d);
        check({tag, "_err"}, rx_err, e);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_err", rx_err, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_break", break_det, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 0xA5 with push latency.
        send_8n1(8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5_level", fifo_level, 1);
        pop_check("a5", 8'hA5, 2'b00);
        check("a5_empty", rx_valid, 0);

        // 7 bits, odd parity, 0x3C with a wrong parity bit (correct would be 1).
        cfg_data_bits = 2'b10; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1;
        send_frame(8'h3C, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        pop_check("par_bad", 8'h3C, 2'b10);

        // 6 bits, even parity, 0x2B (four ones -> parity bit 0 is correct).
        cfg_data_bits = 2'b01; cfg_parity_odd = 1'b0;
        send_frame(8'h2B, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        pop_check("par_ok", 8'h2B, 2'b00);

        // 5 bits, two stop bits, first stop low: frame error, not a break.
        cfg_data_bits = 2'b00; cfg_parity_en = 1'b0; cfg_stop2 = 1'b1;
        brk_before = brk_pulses;
        send_frame(8'h15, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("fe_no_break", brk_pulses - brk_before, 0);
        pop_check("fe", 8'h15, 2'b01);

        // 4-clock low glitch on the idle line is rejected.
        cfg_data_bits = 2'b11; cfg_stop2 = 1'b0;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_level", fifo_level, 0);
        check("glitch_valid", rx_valid, 0);

        // Break: line low for 20 bit times.
        brk_before = brk_pulses;
        rx = 1'b0;
        repeat (20 * D) @(posedge clk);
        #1;
        check("brk_level_low", fifo_level, 1);
        check("brk_pulses", brk_pulses - brk_before, 1);
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("brk_level_high", fifo_level, 1);
        pop_check("brk", 8'h00, 2'b01);
        send_8n1(8'h5A, 1'b1, 1'b0, 1'b0);
        pop_check("after_brk", 8'h5A, 2'b00);

        // Overrun: nine back-to-back frames with no pops.
        for (int k = 1; k <= 9; k++) send_8n1(8'(k), 1'b0, 1'b0, 1'b0);
        check("ovr_level", fifo_level, 8);
        check("ovr_set", overrun, 1);
        check("ovr_head", rx_data, 8'h01);
        ovr_clr = 1'b1;
        @(posedge clk);
        #1;
        ovr_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        // Clear on the same edge as a new drop: drop wins.
        send_8n1(8'h0A, 1'b0, 1'b1, 1'b0);
        check("ovr_clr_vs_drop", overrun, 1);
        check("ovr_level2", fifo_level, 8);
        ovr_clr = 1'b1;
        @(posedge clk);
        #1;
        ovr_clr = 1'b0;
        check("ovr_clr2", overrun, 0);
        // Push and pop on the same edge while full: both succeed.
        send_8n1(8'h0B, 1'b0, 1'b0, 1'b1);
        check("full_pushpop_level", fifo_level, 8);
        check("full_pushpop_ovr", overrun, 0);
        for (int k = 2; k <= 8; k++) pop_check("drain", 8'(k), 2'b00);
        pop_check("drain_last", 8'h0B, 2'b00);
        check("drain_level", fifo_level, 0);

        // Reset in the middle of a frame's data bits, FIFO holding one entry.
        send_8n1(8'h77, 1'b0, 1'b0, 1'b0);
        check("pre_rst_level", fifo_level, 1);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_err", rx_err, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_break", break_det, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_8n1(8'hC3, 1'b1, 1'b0, 1'b0);
        check("post_rst_level", fifo_level, 1);
        pop_check("post_rst", 8'hC3, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
